// File: rtl/clock_pkg.sv
// Shared types and constants for the clock display pipeline.
// The CORDIC scheduler and its arbiter use these; there is no logic here.
package clock_pkg;

  localparam int ANGLE_W = 16;
  localparam int DATA_W  = 16;

  // Largest legal angle is ANGLE_MAX-1 degrees; anything at or above is rejected.
  localparam logic [ANGLE_W-1:0] ANGLE_MAX = 16'd360;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_scheduler_if.sv
// Requester-side and CORDIC-side signals of the scheduler.
// slave is the scheduler's view; master is the surrounding environment's view.
interface cordic_scheduler_if #(
  parameter int N_REQ = 4
);
  import clock_pkg::*;

  logic [N_REQ-1:0]         req;
  logic [ANGLE_W*N_REQ-1:0] req_angle;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         rsp_valid;
  logic signed [DATA_W-1:0] rsp_sin;
  logic signed [DATA_W-1:0] rsp_cos;
  logic                     rsp_err;
  logic                     busy;
  logic                     cordic_start;
  logic [ANGLE_W-1:0]       cordic_angle;
  logic signed [DATA_W-1:0] cordic_sin;
  logic signed [DATA_W-1:0] cordic_cos;
  logic                     cordic_done;

  modport slave (
    input  req, req_angle, cordic_sin, cordic_cos, cordic_done,
    output gnt, rsp_valid, rsp_sin, rsp_cos, rsp_err, busy,
           cordic_start, cordic_angle
  );

  modport master (
    output req, req_angle, cordic_sin, cordic_cos, cordic_done,
    input  gnt, rsp_valid, rsp_sin, rsp_cos, rsp_err, busy,
           cordic_start, cordic_angle
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request searching upward from last+1, wrapping.
// Purely combinational, zero latency; no backpressure (win is 0 when req is 0).
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    last,
  output logic [N_REQ-1:0] win,
  output logic [PW-1:0]    win_idx
);

  logic found;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      int cand;
      cand = (int'(last) + off) % N_REQ;
      if (!found && req[PW'(cand)]) begin
        found   = 1'b1;
        win_idx = PW'(cand);
      end
    end
    win = found ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one CORDIC among N_REQ requesters round-robin, with a done watchdog.
// Grant 1 cycle after request; response 1 cycle after done (or TIMEOUT+1 after launch).
// Requesters hold req until gnt; nothing is queued beyond the req levels.
module cordic_scheduler
  import clock_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               reset,
  cordic_scheduler_if.slave  bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int WD = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [PW-1:0]      last;
  logic [N_REQ-1:0]   cur_oh;
  logic [WD-1:0]      wdog;

  logic [N_REQ-1:0]   win;
  logic [PW-1:0]      win_idx;
  logic [ANGLE_W-1:0] win_angle;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .req     (bus.req),
    .last    (last),
    .win     (win),
    .win_idx (win_idx)
  );

  assign win_angle = bus.req_angle[int'(win_idx)*ANGLE_W +: ANGLE_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      last             <= PW'(N_REQ - 1);
      cur_oh           <= '0;
      wdog             <= '0;
      bus.gnt          <= '0;
      bus.rsp_valid    <= '0;
      bus.rsp_sin      <= '0;
      bus.rsp_cos      <= '0;
      bus.rsp_err      <= 1'b0;
      bus.busy         <= 1'b0;
      bus.cordic_start <= 1'b0;
      bus.cordic_angle <= '0;
    end else begin
      // Pulse outputs default low; each state re-asserts them for one cycle.
      bus.gnt          <= '0;
      bus.rsp_valid    <= '0;
      bus.rsp_err      <= 1'b0;
      bus.cordic_start <= 1'b0;

      case (state)
        IDLE: begin
          if (|bus.req) begin
            cur_oh   <= win;
            last     <= win_idx;
            bus.gnt  <= win;
            bus.busy <= 1'b1;
            if (win_angle < ANGLE_MAX) begin
              state            <= LAUNCH;
              bus.cordic_start <= 1'b1;
              bus.cordic_angle <= win_angle;
            end else begin
              state         <= RESPOND;
              bus.rsp_valid <= win;
              bus.rsp_err   <= 1'b1;
              bus.rsp_sin   <= '0;
              bus.rsp_cos   <= '0;
            end
          end
        end

        // A done seen here belongs to an earlier job, so it is not looked at.
        LAUNCH: begin
          wdog  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (bus.cordic_done) begin
            state         <= RESPOND;
            bus.rsp_valid <= cur_oh;
            bus.rsp_sin   <= bus.cordic_sin;
            bus.rsp_cos   <= bus.cordic_cos;
          end else begin
            wdog <= (wdog == WD'(TIMEOUT)) ? wdog : wdog + 1'b1;
            if (wdog >= WD'(TIMEOUT - 1)) begin
              state         <= RESPOND;
              bus.rsp_valid <= cur_oh;
              bus.rsp_err   <= 1'b1;
              bus.rsp_sin   <= '0;
              bus.rsp_cos   <= '0;
            end
          end
        end

        RESPOND: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: directed steps then random traffic, checked every
// cycle against a transaction-level model of arbitration, timing and results.
module tb_cordic_scheduler;
  import clock_pkg::*;

  localparam int N  = 4;
  localparam int TO = 63;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cordic_scheduler_if #(.N_REQ(N)) bus();

  cordic_scheduler #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int cyc = 0, last_m = N - 1, free_at = 0;
  bit in_flight = 0, job_bad = 0, decided = 0, exp_err = 0, prev_busy = 0;
  int job_idx, job_ang, job_l, exp_due, exp_sin, exp_cos;
  // CORDIC behavioural model
  bit cjob = 0, never_done = 0, stale = 0, hold_all = 0;
  int ccnt = 0, cfg_lat = 16, cang = 0;
  // Observed events
  int gnt_hist[$];
  int gnt_cyc_hist[$];
  int gnt_cyc = 0, start_cyc = 0, start_angle = 0, n_starts = 0, rsp_cyc = 0, n_rsp = 0;
  logic [31:0] r_sin, r_cos, r_vld;
  logic        r_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int q14(input real x);
    real r;
    r = x * 16384.0;
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int q_sin(input int deg);
    return q14($sin(deg * 3.141592653589793 / 180.0));
  endfunction

  function automatic int q_cos(input int deg);
    return q14($cos(deg * 3.141592653589793 / 180.0));
  endfunction

  // One cycle: observe DUT outputs at the falling edge, check them against the
  // model, then drive the CORDIC model and requesters for the next rising edge.
  task automatic tick();
    logic [N-1:0] eg;
    logic [N-1:0] erv;
    int w;
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_sin", bus.rsp_sin, 0);
      chk("rst_rsp_cos", bus.rsp_cos, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cordic_start", bus.cordic_start, 0);
      chk("rst_cordic_angle", bus.cordic_angle, 0);
      in_flight = 0; decided = 0; cjob = 0; last_m = N - 1; free_at = cyc; prev_busy = 0;
      bus.cordic_done = 1'b0;
      return;
    end

    eg = '0;
    w  = -1;
    if (!in_flight && cyc - 1 >= free_at && bus.req != 0) begin
      for (int o = 1; o <= N; o++) begin
        int i;
        i = (last_m + o) % N;
        if (w < 0 && bus.req[i]) w = i;
      end
      eg[w] = 1'b1;
    end
    chk("gnt", bus.gnt, eg);
    chk("gnt_onehot", $countones(bus.gnt) <= 1, 1);
    chk("gnt_while_busy", (bus.gnt != 0) && prev_busy, 0);

    if (w >= 0) begin
      last_m  = w;
      job_idx = w;
      job_ang = int'(bus.req_angle[16*w +: 16]);
      job_l   = cyc;
      job_bad = (job_ang >= 360);
      in_flight = 1; decided = 0; exp_err = 1; exp_sin = 0; exp_cos = 0;
      exp_due = job_bad ? cyc : cyc + TO + 1;
      gnt_hist.push_back(w);
      gnt_cyc_hist.push_back(cyc);
      gnt_cyc = cyc;
    end
    chk("cordic_start", bus.cordic_start, (w >= 0) && !job_bad);
    if (in_flight && !job_bad) chk("cordic_angle", bus.cordic_angle, job_ang);
    chk("busy", bus.busy, in_flight);
    if (bus.cordic_start) begin
      n_starts++;
      start_cyc   = cyc;
      start_angle = int'(bus.cordic_angle);
    end

    erv = (in_flight && cyc == exp_due) ? (N'(1) << job_idx) : '0;
    chk("rsp_valid", bus.rsp_valid, erv);
    if (erv != 0) begin
      chk("rsp_sin", $signed(bus.rsp_sin), exp_sin);
      chk("rsp_cos", $signed(bus.rsp_cos), exp_cos);
      chk("rsp_err", bus.rsp_err, exp_err);
      r_sin = $signed(bus.rsp_sin); r_cos = $signed(bus.rsp_cos);
      r_err = bus.rsp_err; r_vld = bus.rsp_valid;
      rsp_cyc = cyc; n_rsp++;
      in_flight = 0;
      free_at   = cyc + 1;
    end
    prev_busy = bus.busy;

    bus.cordic_done = 1'b0;
    bus.cordic_sin  = 16'($urandom);
    bus.cordic_cos  = 16'($urandom);
    if (bus.cordic_start) begin
      cjob = 1; ccnt = cfg_lat; cang = int'(bus.cordic_angle);
      if (stale) bus.cordic_done = 1'b1;
    end else if (cjob && !never_done) begin
      if (ccnt == 0) begin
        bus.cordic_done = 1'b1;
        bus.cordic_sin  = 16'(q_sin(cang));
        bus.cordic_cos  = 16'(q_cos(cang));
        cjob = 0;
        if (in_flight && !job_bad && !decided && cyc <= job_l + TO) begin
          decided = 1; exp_due = cyc + 1; exp_err = 0;
          exp_sin = q_sin(job_ang); exp_cos = q_cos(job_ang);
        end
      end else begin
        ccnt--;
      end
    end

    if (bus.gnt != 0 && !hold_all) bus.req = bus.req & ~bus.gnt;
  endtask

  task automatic set_req(input int i, input int ang);
    bus.req_angle[16*i +: 16] = 16'(ang);
    bus.req[i] = 1'b1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_gnt(input string tag, input int budget);
    int n0, k;
    n0 = gnt_hist.size();
    k = 0;
    while (gnt_hist.size() == n0 && k < budget) begin tick(); k++; end
    chk(tag, gnt_hist.size() > n0, 1);
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n0, k;
    n0 = n_rsp;
    k = 0;
    while (n_rsp == n0 && k < budget) begin tick(); k++; end
    chk(tag, n_rsp > n0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int c0, s0, r0, base;
    bus.req = '0; bus.req_angle = '0;
    bus.cordic_done = 1'b0; bus.cordic_sin = '0; bus.cordic_cos = '0;

    // Reset state
    tick(); tick();
    reset = 1'b0;

    // Single request, angle 90, CORDIC latency 16
    cfg_lat = 16;
    c0 = cyc;
    set_req(0, 90);
    wait_gnt("single_gnt_wait", 20);
    chk("single_gnt_cycle", gnt_cyc, c0 + 1);
    chk("single_gnt_idx", gnt_hist[gnt_hist.size()-1], 0);
    chk("single_cordic_angle", start_angle, 90);
    wait_rsp("single_rsp_wait", 100);
    chk("single_rsp_valid", r_vld, 1);
    chk("single_rsp_sin", r_sin, 16384);
    chk("single_rsp_cos", r_cos, 0);
    chk("single_rsp_err", r_err, 0);
    chk("single_rsp_latency", rsp_cyc - start_cyc, cfg_lat + 2);

    // Round-robin with all requests held
    do_reset();
    cfg_lat = 3;
    hold_all = 1;
    base = gnt_hist.size();
    for (int i = 0; i < N; i++) set_req(i, 10 * (i + 1));
    for (int k = 0; k < 200 && gnt_hist.size() < base + 5; k++) tick();
    chk("rr_count", gnt_hist.size() >= base + 5, 1);
    if (gnt_hist.size() >= base + 5) begin
      chk("rr_order0", gnt_hist[base+0], 0);
      chk("rr_order1", gnt_hist[base+1], 1);
      chk("rr_order2", gnt_hist[base+2], 2);
      chk("rr_order3", gnt_hist[base+3], 3);
      chk("rr_order4", gnt_hist[base+4], 0);
      chk("rr_turnaround", gnt_cyc_hist[base+1] - gnt_cyc_hist[base+0], 4 + cfg_lat);
    end
    hold_all = 0;
    bus.req = '0;
    for (int k = 0; k < 100 && in_flight; k++) tick();
    tick(); tick();

    // Watchdog timeout, then a normal job
    never_done = 1;
    set_req(0, 45);
    wait_rsp("to_rsp_wait", 200);
    chk("to_rsp_delay", rsp_cyc - start_cyc, TO + 1);
    chk("to_rsp_err", r_err, 1);
    chk("to_rsp_sin", r_sin, 0);
    chk("to_rsp_cos", r_cos, 0);
    never_done = 0;
    cfg_lat = 5;
    set_req(1, 180);
    wait_rsp("after_to_rsp_wait", 100);
    chk("after_to_valid", r_vld, 2);
    chk("after_to_err", r_err, 0);
    chk("after_to_sin", r_sin, 0);
    chk("after_to_cos", r_cos, 32'hFFFF_C000);

    // Stale done during LAUNCH is ignored
    stale = 1;
    set_req(2, 30);
    wait_rsp("stale_rsp_wait", 100);
    chk("stale_err", r_err, 0);
    chk("stale_sin", r_sin, 8192);
    chk("stale_cos", r_cos, 14189);
    chk("stale_delay", rsp_cyc - start_cyc, cfg_lat + 2);
    stale = 0;

    // Rejected angle: grant, response and error together, no launch
    s0 = n_starts;
    set_req(3, 400);
    wait_rsp("bad_rsp_wait", 20);
    chk("bad_gnt_with_rsp", gnt_cyc, rsp_cyc);
    chk("bad_valid", r_vld, 8);
    chk("bad_err", r_err, 1);
    chk("bad_no_start", n_starts - s0, 0);
    tick(); tick();

    // Done on the last WAIT cycle wins; one cycle later is a timeout
    cfg_lat = TO - 1;
    set_req(0, 270);
    wait_rsp("edge_done_wait", 200);
    chk("edge_done_err", r_err, 0);
    chk("edge_done_sin", r_sin, 32'hFFFF_C000);
    chk("edge_done_delay", rsp_cyc - start_cyc, TO + 1);
    cfg_lat = TO;
    set_req(0, 0);
    wait_rsp("edge_late_wait", 200);
    chk("edge_late_err", r_err, 1);
    chk("edge_late_delay", rsp_cyc - start_cyc, TO + 1);
    tick(); tick(); tick();

    // Reset while waiting on the CORDIC
    cfg_lat = 40;
    set_req(0, 60);
    wait_gnt("midrst_gnt_wait", 20);
    for (int k = 0; k < 5; k++) tick();
    r0 = n_rsp;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 80; k++) tick();
    chk("midrst_no_rsp", n_rsp - r0, 0);
    cfg_lat = 2;
    set_req(1, 120);
    set_req(2, 240);
    wait_gnt("midrst_next_gnt_wait", 20);
    chk("midrst_first_winner", gnt_hist[gnt_hist.size()-1], 1);
    for (int k = 0; k < 40; k++) tick();

    // Random traffic
    base = gnt_hist.size();
    for (int k = 0; k < 3000; k++) begin
      cfg_lat    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(55, 70)) : int'($urandom_range(0, 8));
      never_done = ($urandom_range(0, 40) == 0);
      stale      = ($urandom_range(0, 3) == 0);
      hold_all   = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 3) == 0)
          set_req(i, ($urandom_range(0, 9) == 0) ? int'($urandom_range(360, 65535)) : int'($urandom_range(0, 359)));
        else if (bus.req[i] && $urandom_range(0, 60) == 0)
          bus.req[i] = 1'b0;
      end
      reset = ($urandom_range(0, 700) == 0);
      tick();
    end
    reset = 1'b0;
    tick();
    chk("random_progress", gnt_hist.size() - base > 50, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
